alu_op_issuer: RTL and testbench
================================

// Module: alu_op_issuer
// PURPOSE
//  Initiator for the 8-bit combinational ALU operand/opcode interface. Accepts operation
//  commands on a valid/ready stream, drives A/B/opcode into an external ALU instance,
//  waits a fixed settle time, samples the result, and returns it through a response FIFO.
//  Sits between a command source (CPU/test sequencer) and the ALU datapath.
// PARAMETERS
//  W          8  operand/result width; must match the ALU instance
//  SETTLE     1  cycles ALU inputs are held before result is sampled (>=1)
//  RSP_DEPTH  4  response FIFO entries (power of 2, >=2)
// PORTS
//  clk          in   1  single clock, rising edge
//  rst_n        in   1  asynchronous active-low reset
//  cmd_valid_i  in   1  command valid
//  cmd_ready_o  out  1  command accepted when valid&ready at clk edge
//  cmd_op_i     in   3  opcode: 000 ~A, 001 OR, 010 XOR, 011 AND, 100 MUL, 101 ADD, 110 SUB, 111 zero
//  cmd_a_i      in   W  operand A
//  cmd_b_i      in   W  operand B
//  cmd_chain_i  in   1  use previous result as A (see CONFIGURATION)
//  alu_a_o      out  W  to ALU A (registered)
//  alu_b_o      out  W  to ALU B (registered)
//  alu_op_o     out  3  to ALU opcode (registered)
//  alu_res_i    in   W  from ALU out
//  rsp_valid_o  out  1  FIFO head valid (first-word fall-through)
//  rsp_ready_i  in   1  pop head when valid&ready
//  rsp_data_o   out  W  result
//  rsp_op_o     out  3  opcode that produced rsp_data_o
//  rsp_zero_o   out  1  rsp_data_o == 0
//  busy_o       out  1  FSM not in IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0): FSM->IDLE, FIFO emptied, settle counter 0, last-result reg 0;
//    alu_a_o=0, alu_b_o=0, alu_op_o=3'b111, rsp_valid_o=0, busy_o=0, cmd_ready_o=0 while
//    rst_n low. In-flight command dropped, never responded.
//  - FSM IDLE: cmd_ready_o = (fifo_count < RSP_DEPTH). On accept: alu_a_o/alu_b_o/alu_op_o
//    load command at the same edge, counter=SETTLE-1, ->DRIVE.
//  - DRIVE: cmd_ready_o=0, ALU inputs held. Counter decrements each edge; at the edge where
//    counter==0: push {alu_res_i, alu_op_o, zero} into FIFO, update last-result, ->IDLE.
//  - Latency: accept edge t -> push edge t+SETTLE; rsp_valid_o high from t+SETTLE.
//    Throughput: 1 command per SETTLE+1 cycles. ALU outputs hold last values in IDLE.
//  - Only one command in flight; IDLE admission guarantees a free FIFO slot at push time.
//  - Simultaneous push and pop: count unchanged, order preserved. Pop on empty ignored.
//  - Full: cmd_ready_o=0 in IDLE until a pop; pop at edge e -> cmd_ready_o high after e.
//  - Arithmetic is the ALU's: results truncated to W bits (MUL low byte, SUB wraps mod 2^W);
//    issuer adds no flags other than rsp_zero_o. Opcode 111 yields 0, zero=1.
//  - Pointers wrap mod RSP_DEPTH; count is log2(RSP_DEPTH)+1 bits.
// CONFIGURATION
//  ALU_ISSUER_CHAIN_EN defined: at accept with cmd_chain_i=1, alu_a_o loads last-result
//    (most recent pushed result, 0 after reset) instead of cmd_a_i; cmd_b_i/cmd_op_i as usual.
//  Undefined: cmd_chain_i ignored; no last-result register; alu_a_o always from cmd_a_i.
// TESTING
//  1 Reset: hold rst_n=0 mid-DRIVE -> alu_op_o=111, rsp_valid_o=0, busy_o=0; release ->
//    cmd_ready_o=1 next cycle, no response for dropped command.
//  2 ADD A=8'h0F B=8'h01 (SETTLE=1) -> rsp_valid_o 1 cycle after accept, data=8'h10, zero=0,
//    rsp_op_o=101.
//  3 SUB 8'h00-8'h01 -> 8'hFF; MUL 8'h10*8'h10 -> 8'h00 zero=1; NOT A=8'hA5 -> 8'h5A.
//  4 rsp_ready_i=0, 5 commands -> 4 accepted, cmd_ready_o=0; one pop -> 5th accepted;
//    drain returns all 5 in order.
//  5 Continuous rsp_ready_i=1 with back-to-back commands -> push/pop same edge, count stays <=1,
//    one response per 2 cycles.
//  6 CHAIN_EN: ADD 3+4 -> 7, then chain ADD B=1 (cmd_a_i=8'h50) -> 8; macro undefined -> 8'h51.

Source files
------------

// File: rtl/alu_op_issuer.sv
// Issues one command at a time to an external combinational ALU and returns results via FIFO.
// Optional feature: define ALU_ISSUER_CHAIN_EN to let a command take the previous result as A.
module alu_op_issuer #(
    parameter int unsigned W         = 8,
    parameter int unsigned SETTLE    = 1,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic [2:0]   cmd_op_i,
    input  logic [W-1:0] cmd_a_i,
    input  logic [W-1:0] cmd_b_i,
    input  logic         cmd_chain_i,
    output logic [W-1:0] alu_a_o,
    output logic [W-1:0] alu_b_o,
    output logic [2:0]   alu_op_o,
    input  logic [W-1:0] alu_res_i,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic [W-1:0] rsp_data_o,
    output logic [2:0]   rsp_op_o,
    output logic         rsp_zero_o,
    output logic         busy_o
);

    localparam int unsigned AW = $clog2(RSP_DEPTH);
    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(RSP_DEPTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRIVE = 1'b1;

    logic [0:0]    state_q;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   count_q;
    logic [W-1:0]  a_sel;
    logic          accept, push, pop;

    logic [W-1:0] mem_data [RSP_DEPTH];
    logic [2:0]   mem_op   [RSP_DEPTH];

    // Ready is forced low while reset is asserted, not just after it.
    assign cmd_ready_o = rst_n && (state_q == IDLE) && (count_q < FULL_CNT);
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign push        = (state_q == DRIVE) && (cnt_q == '0);
    assign rsp_valid_o = (count_q != '0);
    assign pop         = rsp_valid_o && rsp_ready_i;
    assign busy_o      = (state_q == DRIVE);
    assign rsp_data_o  = mem_data[rd_q];
    assign rsp_op_o    = mem_op[rd_q];
    assign rsp_zero_o  = (rsp_data_o == '0);

`ifdef ALU_ISSUER_CHAIN_EN
    logic [W-1:0] last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= '0;
        end else if (push) begin
            last_q <= alu_res_i;
        end
    end

    assign a_sel = cmd_chain_i ? last_q : cmd_a_i;
`else
    logic unused_chain;
    assign unused_chain = cmd_chain_i;
    assign a_sel        = cmd_a_i;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            alu_a_o  <= '0;
            alu_b_o  <= '0;
            alu_op_o <= 3'b111;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        alu_a_o  <= a_sel;
                        alu_b_o  <= cmd_b_i;
                        alu_op_o <= cmd_op_i;
                        cnt_q    <= CNT_INIT;
                        state_q  <= DRIVE;
                    end
                end
                default: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_q] <= alu_res_i;
            mem_op[wr_q]   <= alu_op_o;
        end
    end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed and randomized bench for alu_op_issuer with a stand-in ALU and a queue-based model.
module tb_alu_op_issuer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid_i, cmd_ready_o, cmd_chain_i;
    logic [2:0] cmd_op_i;
    logic [7:0] cmd_a_i, cmd_b_i;
    logic [7:0] alu_a_o, alu_b_o, alu_res_i;
    logic [2:0] alu_op_o;
    logic       rsp_valid_o, rsp_ready_i, rsp_zero_o, busy_o;
    logic [7:0] rsp_data_o;
    logic [2:0] rsp_op_o;

    int errors = 0;
    int checks = 0;

`ifdef ALU_ISSUER_CHAIN_EN
    localparam bit CHAIN_ON = 1'b1;
`else
    localparam bit CHAIN_ON = 1'b0;
`endif

    logic [10:0] exp_q[$];  // {op, data}
    logic [7:0]  last_m;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        int r;
        case (op)
            3'd0:    r = 255 - a;
            3'd1:    r = a | b;
            3'd2:    r = a ^ b;
            3'd3:    r = a & b;
            3'd4:    r = (a * b) % 256;
            3'd5:    r = (a + b) % 256;
            3'd6:    r = (a + 256 - b) % 256;
            default: r = 0;
        endcase
        return r[7:0];
    endfunction

    assign alu_res_i = alu_fn(alu_op_o, alu_a_o, alu_b_o);

    alu_op_issuer #(.W(8), .SETTLE(1), .RSP_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
        .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i), .cmd_chain_i(cmd_chain_i),
        .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o), .alu_res_i(alu_res_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .rsp_op_o(rsp_op_o), .rsp_zero_o(rsp_zero_o), .busy_o(busy_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic ch);
        logic [7:0] ea, r;
        ea = (ch && CHAIN_ON) ? last_m : a;
        r  = alu_fn(op, ea, b);
        exp_q.push_back({op, r});
        last_m = r;
    endtask

    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic ch);
        int n = 0;
        cmd_op_i = op; cmd_a_i = a; cmd_b_i = b; cmd_chain_i = ch; cmd_valid_i = 1'b1;
        while (!cmd_ready_o && n < 50) begin
            tick();
            n++;
        end
        check("accept_wait", {31'd0, cmd_ready_o}, 32'd1);
        tick();
        cmd_valid_i = 1'b0;
        push_exp(op, a, b, ch);
    endtask

    task automatic pop_check(input string tag);
        int n = 0;
        logic [10:0] e;
        while (!rsp_valid_o && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, {31'd0, rsp_valid_o}, 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, 32'd1, {31'd0, rsp_valid_o ^ 1'b1});
        end else begin
            e = exp_q.pop_front();
            check({tag, "_data"}, {24'd0, rsp_data_o}, {24'd0, e[7:0]});
            check({tag, "_op"},   {29'd0, rsp_op_o},   {29'd0, e[10:8]});
            check({tag, "_zero"}, {31'd0, rsp_zero_o}, {31'd0, e[7:0] == 8'd0});
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] rop;
        logic [7:0] ra, rb;
        int n_rsp, iter;
        logic acc;

        rst_n = 1'b0; cmd_valid_i = 1'b0; cmd_op_i = 3'd0; cmd_a_i = 8'd0; cmd_b_i = 8'd0;
        cmd_chain_i = 1'b0; rsp_ready_i = 1'b0; last_m = 8'd0;

        // Reset values, then reset during DRIVE drops the command
        tick(); tick();
        check("rst_alu_op", {29'd0, alu_op_o}, 32'd7);
        check("rst_alu_a", {24'd0, alu_a_o}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_ready", {31'd0, cmd_ready_o}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", {31'd0, cmd_ready_o}, 32'd1);
        cmd_op_i = 3'd5; cmd_a_i = 8'h11; cmd_b_i = 8'h22; cmd_valid_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
        check("mid_drive_busy", {31'd0, busy_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_alu_op", {29'd0, alu_op_o}, 32'd7);
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        check("midrst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        check("midrst_ready", {31'd0, cmd_ready_o}, 32'd0);
        tick();
        rst_n = 1'b1;
        last_m = 8'd0;
        tick();
        check("rel_ready", {31'd0, cmd_ready_o}, 32'd1);
        repeat (2) begin
            check("dropped_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
            tick();
        end

        // ADD latency and fields
        cmd_op_i = 3'd5; cmd_a_i = 8'h0F; cmd_b_i = 8'h01; cmd_chain_i = 1'b0;
        cmd_valid_i = 1'b1;
        check("add_ready", {31'd0, cmd_ready_o}, 32'd1);
        tick();
        cmd_valid_i = 1'b0;
        push_exp(3'd5, 8'h0F, 8'h01, 1'b0);
        check("add_busy", {31'd0, busy_o}, 32'd1);
        check("add_not_yet", {31'd0, rsp_valid_o}, 32'd0);
        check("add_alu_a", {24'd0, alu_a_o}, 32'h0F);
        check("add_alu_b", {24'd0, alu_b_o}, 32'h01);
        check("add_alu_op", {29'd0, alu_op_o}, 32'd5);
        tick();
        check("add_valid_t1", {31'd0, rsp_valid_o}, 32'd1);
        check("add_data_const", {24'd0, rsp_data_o}, 32'h10);
        pop_check("add");

        // Wrapping / truncating ops
        issue(3'd6, 8'h00, 8'h01, 1'b0); check("sub_const", {24'd0, alu_res_i}, 32'hFF);
        pop_check("sub");
        issue(3'd4, 8'h10, 8'h10, 1'b0); pop_check("mul");
        issue(3'd0, 8'hA5, 8'h00, 1'b0); check("not_const", {24'd0, alu_res_i}, 32'h5A);
        pop_check("not");
        issue(3'd7, 8'h33, 8'h44, 1'b0); pop_check("zero_op");

        // Fill the FIFO, stall the 5th command, then drain in order
        for (int i = 0; i < 4; i++) issue(3'(i + 1), 8'(8'h30 + i), 8'(8'h0C + i), 1'b0);
        tick();
        check("full_ready", {31'd0, cmd_ready_o}, 32'd0);
        cmd_op_i = 3'd2; cmd_a_i = 8'hF0; cmd_b_i = 8'h0F; cmd_chain_i = 1'b0;
        cmd_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("full_stall", {31'd0, cmd_ready_o | busy_o}, 32'd0);
            tick();
        end
        pop_check("fill0");
        check("after_pop_ready", {31'd0, cmd_ready_o}, 32'd1);
        issue(3'd2, 8'hF0, 8'h0F, 1'b0);
        for (int i = 1; i < 5; i++) pop_check("drain");
        check("drained", {31'd0, rsp_valid_o}, 32'd0);

        // Back-to-back commands with continuous pop: one response every 2 cycles
        rsp_ready_i = 1'b1;
        n_rsp = 0; iter = 0;
        rop = 3'($urandom_range(0, 7)); ra = 8'($urandom); rb = 8'($urandom);
        cmd_op_i = rop; cmd_a_i = ra; cmd_b_i = rb; cmd_chain_i = 1'b0; cmd_valid_i = 1'b1;
        while (n_rsp < 20 && iter < 100) begin
            check("stream_valid", {31'd0, rsp_valid_o},
                  {31'd0, (iter >= 2) && (iter % 2 == 0)});
            if (rsp_valid_o && exp_q.size() > 0) begin
                logic [10:0] e;
                e = exp_q.pop_front();
                check("stream_data", {24'd0, rsp_data_o}, {24'd0, e[7:0]});
                check("stream_op", {29'd0, rsp_op_o}, {29'd0, e[10:8]});
                n_rsp++;
            end
            acc = cmd_valid_i && cmd_ready_o;
            tick();
            iter++;
            if (acc) begin
                push_exp(rop, ra, rb, 1'b0);
                rop = 3'($urandom_range(0, 7)); ra = 8'($urandom); rb = 8'($urandom);
                cmd_op_i = rop; cmd_a_i = ra; cmd_b_i = rb;
                if (n_rsp >= 19) cmd_valid_i = 1'b0;
            end
        end
        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        check("stream_count", n_rsp, 32'd20);
        check("stream_cycles", iter, 32'd41);
        repeat (3) tick();
        while (exp_q.size() > 0) pop_check("stream_tail");

        // Chaining
        issue(3'd5, 8'h03, 8'h04, 1'b0); pop_check("chain_base");
        issue(3'd5, 8'h50, 8'h01, 1'b1);
        check("chain_alu_a", {24'd0, alu_a_o}, CHAIN_ON ? 32'h07 : 32'h50);
        tick();
        check("chain_const", {24'd0, rsp_data_o}, CHAIN_ON ? 32'h08 : 32'h51);
        pop_check("chain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
